// File: rtl/beat_sequencer_if.sv
// rtl/beat_sequencer_if.sv - control and beat-index bundle between board controls, sequencer and note ROM
interface beat_sequencer_if #(
  parameter int BEAT_W = 12,
  parameter int TRK_W  = 1
);
  logic              beat_en;
  logic              _play;
  logic              _repeat;
  logic              _rewind;
  logic              _stop;
  logic [TRK_W-1:0]  track_sel;
  logic [BEAT_W-1:0] ibeat;
  logic [TRK_W-1:0]  track;
  logic [1:0]        state;
  logic              playing;
  logic              done;
  logic              wrap;

  modport master (
    output beat_en, _play, _repeat, _rewind, _stop, track_sel,
    input  ibeat, track, state, playing, done, wrap
  );

  modport slave (
    input  beat_en, _play, _repeat, _rewind, _stop, track_sel,
    output ibeat, track, state, playing, done, wrap
  );
endinterface

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - multi-track beat index sequencer with play/pause, rewind, repeat and beat strobe
module beat_sequencer #(
  parameter int                       BEAT_W   = 12,
  parameter int                       TRACKS   = 2,
  parameter int                       TRK_W    = 1,
  parameter logic [TRACKS*BEAT_W-1:0] LEN_LIST = {12'd4095, 12'd4095}
) (
  input  logic            clk,
  input  logic            reset_n,
  beat_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [BEAT_W-1:0] ONE = BEAT_W'(1);

  state_t            state_q, state_nx;
  logic [BEAT_W-1:0] ibeat_q, ibeat_nx;
  logic [TRK_W-1:0]  track_q, track_nx;
  logic [BEAT_W-1:0] len_q, len_nx;
  logic              wrap_q, wrap_nx;
  logic [TRK_W-1:0]  sel_trk;
  logic [BEAT_W-1:0] sel_len;
  logic [BEAT_W-1:0] last;

  // Unmatched selections fall through to track 0.
  always_comb begin
    sel_trk = '0;
    sel_len = LEN_LIST[0 +: BEAT_W];
    for (int k = 0; k < TRACKS; k++) begin
      if (bus.track_sel == TRK_W'(k)) begin
        sel_trk = TRK_W'(k);
        sel_len = LEN_LIST[k*BEAT_W +: BEAT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOP;
      ibeat_q <= '0;
      track_q <= '0;
      len_q   <= LEN_LIST[0 +: BEAT_W];
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      ibeat_q <= ibeat_nx;
      track_q <= track_nx;
      len_q   <= len_nx;
      wrap_q  <= wrap_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    ibeat_nx = ibeat_q;
    track_nx = track_q;
    len_nx   = len_q;
    wrap_nx  = 1'b0;
    last     = len_q - ONE;

    if (state_q == ST_STOP) begin
      track_nx = sel_trk;
      len_nx   = sel_len;
    end

    if (bus._stop) begin
      state_nx = ST_STOP;
      ibeat_nx = '0;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (bus._play) begin
            state_nx = ST_PLAY;
            ibeat_nx = bus._rewind ? (sel_len - ONE) : '0;
          end
        end
        ST_PLAY: begin
          if (!bus._play) begin
            state_nx = ST_PAUSE;
          end else if (bus.beat_en) begin
            // Direction and repeat are taken from this advancing cycle only.
            if (!bus._rewind) begin
              if (ibeat_q < last) begin
                ibeat_nx = ibeat_q + ONE;
              end else if (bus._repeat) begin
                ibeat_nx = '0;
                wrap_nx  = 1'b1;
              end else begin
                state_nx = ST_END;
              end
            end else begin
              if (ibeat_q != '0) begin
                ibeat_nx = ibeat_q - ONE;
              end else if (bus._repeat) begin
                ibeat_nx = last;
                wrap_nx  = 1'b1;
              end else begin
                state_nx = ST_END;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (bus._play) state_nx = ST_PLAY;
        end
        ST_END: begin
          if (!bus._play) begin
            state_nx = ST_STOP;
            ibeat_nx = '0;
          end
        end
        default: state_nx = ST_STOP;
      endcase
    end
  end

  assign bus.ibeat   = ibeat_q;
  assign bus.track   = track_q;
  assign bus.state   = state_q;
  assign bus.playing = (state_q == ST_PLAY);
  assign bus.done    = (state_q == ST_END);
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - scoreboard bench for beat_sequencer with two short tracks
module tb_beat_sequencer;
  localparam int BEAT_W = 4;
  localparam int TRACKS = 2;
  localparam int TRK_W  = 1;

  typedef struct {
    int ibeat;
    int state;
    int track;
    int wrap;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  int m_state, m_ibeat, m_track, m_len, m_wrap;
  int len_tab[TRACKS] = '{4, 6};

  beat_sequencer_if #(.BEAT_W(BEAT_W), .TRK_W(TRK_W)) bus ();

  beat_sequencer #(
    .BEAT_W  (BEAT_W),
    .TRACKS  (TRACKS),
    .TRK_W   (TRK_W),
    .LEN_LIST({4'd6, 4'd4})
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ibeat = 0;
    m_track = 0;
    m_len   = len_tab[0];
    m_wrap  = 0;
  endtask

  // Reference behaviour: STOP=0 PLAY=1 PAUSE=2 END=3.
  task automatic model_step();
    int sel;
    int nxt_wrap;
    sel = (int'(bus.track_sel) < TRACKS) ? int'(bus.track_sel) : 0;
    nxt_wrap = 0;
    if (m_state == 0) begin
      m_track = sel;
      m_len   = len_tab[sel];
    end
    if (bus._stop) begin
      m_state = 0;
      m_ibeat = 0;
    end else if (m_state == 0) begin
      if (bus._play) begin
        m_state = 1;
        m_ibeat = bus._rewind ? m_len - 1 : 0;
      end
    end else if (m_state == 1) begin
      if (!bus._play) m_state = 2;
      else if (bus.beat_en) begin
        if (!bus._rewind) begin
          if (m_ibeat == m_len - 1) begin
            if (bus._repeat) begin m_ibeat = 0; nxt_wrap = 1; end
            else m_state = 3;
          end else m_ibeat = m_ibeat + 1;
        end else begin
          if (m_ibeat == 0) begin
            if (bus._repeat) begin m_ibeat = m_len - 1; nxt_wrap = 1; end
            else m_state = 3;
          end else m_ibeat = m_ibeat - 1;
        end
      end
    end else if (m_state == 2) begin
      if (bus._play) m_state = 1;
    end else begin
      if (!bus._play) begin m_state = 0; m_ibeat = 0; end
    end
    m_wrap = nxt_wrap;
  endtask

  task automatic compare_outputs(input exp_t e);
    check("ibeat",   int'(bus.ibeat),   e.ibeat);
    check("state",   int'(bus.state),   e.state);
    check("track",   int'(bus.track),   e.track);
    check("wrap",    int'(bus.wrap),    e.wrap);
    check("playing", int'(bus.playing), (e.state == 1) ? 1 : 0);
    check("done",    int'(bus.done),    (e.state == 3) ? 1 : 0);
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_step();
      e.ibeat = m_ibeat;
      e.state = m_state;
      e.track = m_track;
      e.wrap  = m_wrap;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        compare_outputs(e);
      end
    end
  endtask

  task automatic drive(input bit be, input bit pl, input bit rp, input bit rw, input bit st, input bit ts);
    bus.beat_en   = be;
    bus._play     = pl;
    bus._repeat   = rp;
    bus._rewind   = rw;
    bus._stop     = st;
    bus.track_sel = ts;
  endtask

  initial begin
    int wraps;
    exp_t rst_e;
    n_tests = 0;
    n_fail  = 0;
    rst_e.ibeat = 0;
    rst_e.state = 0;
    rst_e.track = 0;
    rst_e.wrap  = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs(rst_e);
    reset_n = 1'b1;

    // Forward, no repeat: 0,1,2,3 then END holding 3, then STOP.
    drive(1, 1, 0, 0, 0, 0);
    step(6);
    check("end_ibeat", int'(bus.ibeat), 3);
    check("end_done",  int'(bus.done),  1);
    bus._play = 1'b0;
    step(1);
    check("end_to_stop", int'(bus.state), 0);

    // Forward repeat on track 0: two wraps across ten cycles.
    drive(1, 1, 1, 0, 0, 0);
    wraps = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      wraps += int'(bus.wrap);
    end
    check("wrap_count", wraps, 2);

    // Rewind repeat on track 1; mid-play track_sel change ignored.
    drive(1, 1, 1, 1, 1, 1);
    step(1);
    bus._stop = 1'b0;
    step(1);
    check("rew_entry", int'(bus.ibeat), 5);
    bus.track_sel = 1'b0;
    step(6);
    check("rew_wrap_beat",  int'(bus.ibeat), 5);
    check("rew_wrap_pulse", int'(bus.wrap),  1);
    check("rew_track_kept", int'(bus.track), 1);

    // Pause holds beat with beat_en high, resume continues.
    drive(1, 0, 0, 0, 1, 0);
    step(1);
    drive(1, 1, 0, 0, 0, 0);
    step(3);
    bus._play = 1'b0;
    step(5);
    check("pause_beat",  int'(bus.ibeat), 2);
    check("pause_state", int'(bus.state), 2);
    bus._play = 1'b1;
    step(2);
    check("resume_beat", int'(bus.ibeat), 3);

    // Stop together with beat_en at ibeat 2.
    drive(1, 0, 0, 0, 1, 0);
    step(1);
    drive(1, 1, 0, 0, 0, 0);
    step(3);
    bus._stop = 1'b1;
    step(1);
    check("stop_beat", int'(bus.ibeat), 0);
    drive(0, 0, 0, 0, 0, 0);
    step(1);

    // Idle strobe, then direction flip at ibeat 2.
    drive(1, 1, 0, 0, 0, 0);
    step(3);
    bus.beat_en = 1'b0;
    step(10);
    check("idle_beat", int'(bus.ibeat), 2);
    bus.beat_en = 1'b1;
    bus._rewind = 1'b1;
    step(1);
    check("flip_beat", int'(bus.ibeat), 1);

    // Asynchronous reset mid-song on track 1.
    drive(0, 0, 0, 0, 1, 1);
    step(1);
    drive(1, 1, 0, 0, 0, 1);
    step(3);
    check("pre_rst_track", int'(bus.track), 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_outputs(rst_e);
    @(posedge clk);
    #1;
    compare_outputs(rst_e);
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Parametrised successor to the single-track beat counter; drives the `ibeat` index into the note ROMs of the sound path.
- Adds multiple tracks with per-track lengths, play/pause, forward/rewind direction, repeat-or-stop at song end, and advance gated by a beat strobe rather than every clock.
- Sits between the board controls (debounced/one-pulsed upstream) and the music ROM / tone generator.

Parameters:
- BEAT_W, 12, width of the beat index.
- TRACKS, 2, number of selectable tracks (≥1).
- TRK_W, 1, width of `track_sel`; must satisfy 2^TRK_W ≥ TRACKS.
- LEN_LIST, {12'd4095, 12'd4095}, packed list of TRACKS×BEAT_W track lengths; track k occupies bits [k*BEAT_W +: BEAT_W]. Each length L satisfies 2 ≤ L ≤ 2^BEAT_W−1.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- beat_en, input, 1, one-cycle strobe; the beat advances only on cycles where it is high.
- _play, input, 1, level: 1 = play, 0 = pause.
- _repeat, input, 1, level: 1 = wrap at song end, 0 = stop at song end.
- _rewind, input, 1, level: 1 = count down, 0 = count up.
- _stop, input, 1, synchronous stop/rewind-to-start request.
- track_sel, input, TRK_W, requested track.
- ibeat, output, BEAT_W, current beat index.
- track, output, TRK_W, track currently loaded.
- state, output, 2, 0 = STOP, 1 = PLAY, 2 = PAUSE, 3 = END.
- playing, output, 1, high only in PLAY.
- done, output, 1, high only in END.
- wrap, output, 1, one-cycle pulse on each repeat wrap.

Behaviour:
- Reset (reset_n low, asynchronous): state = STOP, ibeat = 0, track = 0, cur_len = LEN of track 0, wrap = 0. Therefore playing = 0 and done = 0. All outputs are registered; playing and done decode from state.
- Out-of-range track_sel (≥ TRACKS) is treated as track 0.
- Priority each cycle: _stop > state transition > beat advance.
- _stop high in any state → STOP next cycle, ibeat = 0.
- STOP:
  - track and cur_len reload from track_sel every cycle.
  - If _play = 1 → PLAY. On entry, ibeat = 0 if _rewind = 0, else cur_len−1. No advance occurs in the entry cycle.
- PLAY:
  - _play = 0 → PAUSE, ibeat held; beat_en in that cycle is ignored.
  - Otherwise, on beat_en:
    - Forward: if ibeat < cur_len−1, ibeat+1. At cur_len−1 with _repeat = 1: ibeat = 0 and wrap pulses. At cur_len−1 with _repeat = 0: ibeat holds cur_len−1 and state → END.
    - Rewind: if ibeat > 0, ibeat−1. At 0 with _repeat = 1: ibeat = cur_len−1 and wrap pulses. At 0 with _repeat = 0: ibeat holds 0 and state → END.
  - Direction and repeat are sampled on the advancing cycle, so toggling _rewind mid-song reverses from the current beat.
- PAUSE: ibeat frozen, beat_en ignored; _play = 1 → PLAY (resume from held beat, no reload).
- END: ibeat frozen. _play = 0 → STOP with ibeat = 0. Setting _repeat = 1 alone does not restart playback.
- track_sel changes outside STOP are ignored; the new track takes effect only after returning to STOP.
- Arithmetic is BEAT_W-bit unsigned; comparisons use cur_len−1, so no overflow occurs for L ≤ 2^BEAT_W−1.
- wrap is 0 in every cycle without a wrap event.
- Asserting reset_n low mid-song returns all state to reset values immediately; there is no resume after reset.

Test Plan:
- Use BEAT_W = 4, TRACKS = 2, LEN_LIST = {4'd6, 4'd4} (track 1 = 6, track 0 = 4).
- Reset, _play = 1, _repeat = 0, _rewind = 0, beat_en every cycle → ibeat 0,1,2,3; state = END with done = 1; ibeat holds 3. Drop _play → STOP, ibeat = 0.
- _repeat = 1, forward, track 0 → ibeat 0,1,2,3,0,1…; wrap pulses exactly in the cycle ibeat becomes 0 after 3, never otherwise.
- track_sel = 1 in STOP, _rewind = 1, _repeat = 1, play → entry ibeat = 5, then 4,3,2,1,0,5 with a wrap pulse. Changing track_sel to 0 mid-play leaves track = 1.
- Forward play to ibeat = 2; drop _play with beat_en held high for 5 cycles → ibeat stays 2, state = PAUSE. Raise _play → next beat_en gives 3.
- At ibeat = 2 in PLAY, assert _stop together with beat_en → STOP, ibeat = 0, no advance. Separately, pull reset_n low asynchronously mid-song → outputs return to reset values before the next clk edge.
- beat_en low for 10 cycles in PLAY → ibeat unchanged. Toggle _rewind at ibeat = 2 → next beat_en gives 1.
